fpu_bus_if: RTL and testbench

Byte-wide CPU bus front end for the `fpu` core. It sits directly upstream of `fpu`. The CPU loads operand A, operand B and the opcode through 8-bit register writes, then triggers a command. The block drives the fpu `start`/`cmd_end` handshake, captures `ieee_packet_out` into a result register, and raises a level interrupt on completion.

---
 rtl/fpu_bus_if.sv | 145 ++++++++++++++
 tb/tb_fpu_bus_if.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_bus_if.sv
// fpu_bus_if: byte-wide CPU register front end driving the fpu handshake.
// Optional interrupt logic is compiled in with FPU_BUS_IF_IRQ_EN.
package pa_fpu;
   typedef enum logic [1:0] {
      op_add = 2'd0,
      op_sub = 2'd1,
      op_mul = 2'd2,
      op_div = 2'd3
   } e_fpu_op;
endpackage

module fpu_bus_if
   import pa_fpu::*;
(
   input  logic        clk,
   input  logic        arst,
   input  logic        cs,
   input  logic        wr,
   input  logic        rd,
   input  logic [3:0]  addr,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        irq,
   output logic [31:0] a_operand,
   output logic [31:0] b_operand,
   output e_fpu_op     operation,
   output logic        start,
   input  logic        cmd_end,
   input  logic        busy,
   input  logic [31:0] ieee_packet_out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, b_q, result_q;
   logic [1:0]  op_q;
   logic        done_q, cmd_end_q;
   logic        irq_en_q, irq_pend_q;
   logic        wr_en, rd_en, idle, ctrl_wr;
   logic        go, cmd_edge, capture;
   logic [1:0]  res_idx;
   logic [4:0]  byte_sel;
   logic [4:0]  res_sel;

   assign wr_en    = cs & wr;
   assign rd_en    = cs & rd;
   assign idle     = (state_q == S_IDLE);
   assign ctrl_wr  = wr_en & (addr == 4'd9);
   assign go       = ctrl_wr & data_in[0] & idle;
   assign cmd_edge = cmd_end & ~cmd_end_q;
   assign capture  = (state_q == S_RUN) & cmd_edge;
   assign res_idx  = addr[1:0] - 2'd2;
   assign byte_sel = {addr[1:0], 3'b000};
   assign res_sel  = {res_idx, 3'b000};

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (go) state_d = S_RUN;
         S_RUN:   if (cmd_edge) state_d = S_DRAIN;
         S_DRAIN: if (!cmd_end) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state_q   <= S_IDLE;
         cmd_end_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_end_q <= cmd_end;
         // operands are frozen while the fpu owns them
         if (wr_en && idle) begin
            if (addr[3:2] == 2'd0) a_q[byte_sel +: 8] <= data_in;
            if (addr[3:2] == 2'd1) b_q[byte_sel +: 8] <= data_in;
            if (addr == 4'd8) op_q <= data_in[1:0];
         end
         if (go) done_q <= 1'b0;
         else if (capture) done_q <= 1'b1;
         if (capture) result_q <= ieee_packet_out;
      end
   end

`ifdef FPU_BUS_IF_IRQ_EN
   logic irq_clr;

   assign irq_clr = (ctrl_wr & data_in[1])
                  | (rd_en & (addr == 4'd13));

   // a capture outranks a concurrent acknowledge
   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         irq_en_q   <= 1'b0;
         irq_pend_q <= 1'b0;
      end else begin
         if (ctrl_wr) irq_en_q <= data_in[3];
         if (capture && irq_en_q) irq_pend_q <= 1'b1;
         else if (irq_clr) irq_pend_q <= 1'b0;
      end
   end
`else
   logic unused_rd;

   assign unused_rd  = rd;
   assign irq_en_q   = 1'b0;
   assign irq_pend_q = 1'b0;
`endif

   assign irq       = irq_pend_q;
   assign start     = (state_q == S_RUN);
   assign a_operand = a_q;
   assign b_operand = b_q;
   assign operation = e_fpu_op'(op_q);

   always_comb begin
      data_out = 8'h00;
      case (addr)
         4'd0, 4'd1, 4'd2, 4'd3:
            data_out = a_q[byte_sel +: 8];
         4'd4, 4'd5, 4'd6, 4'd7:
            data_out = b_q[byte_sel +: 8];
         4'd8:
            data_out = {6'd0, op_q};
         4'd9:
            data_out = {3'd0, busy, irq_en_q,
                        irq_pend_q, done_q, ~idle};
         4'd10, 4'd11, 4'd12, 4'd13:
            data_out = result_q[res_sel +: 8];
         default:
            data_out = 8'h00;
      endcase
   end

endmodule

// File: tb/tb_fpu_bus_if.sv
// tb_fpu_bus_if: register-level model plus directed fpu stub scenarios.
// Interrupt expectations follow FPU_BUS_IF_IRQ_EN.
`timescale 1ns/1ps
module tb_fpu_bus_if;
   import pa_fpu::*;

`ifdef FPU_BUS_IF_IRQ_EN
   localparam bit IRQ = 1'b1;
`else
   localparam bit IRQ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        arst = 1'b0;
   logic        cs = 1'b0;
   logic        wr = 1'b0;
   logic        rd = 1'b0;
   logic [3:0]  addr = 4'd0;
   logic [7:0]  data_in = 8'd0;
   logic        cmd_end = 1'b0;
   logic        busy = 1'b0;
   logic [31:0] pkt = 32'd0;
   logic [7:0]  data_out;
   logic        irq;
   logic        start;
   logic [31:0] a_operand;
   logic [31:0] b_operand;
   e_fpu_op     operation;

   int total = 0;
   int bad = 0;
   int starts = 0;

   fpu_bus_if dut (
      .clk(clk),
      .arst(arst),
      .cs(cs),
      .wr(wr),
      .rd(rd),
      .addr(addr),
      .data_in(data_in),
      .data_out(data_out),
      .irq(irq),
      .a_operand(a_operand),
      .b_operand(b_operand),
      .operation(operation),
      .start(start),
      .cmd_end(cmd_end),
      .busy(busy),
      .ieee_packet_out(pkt)
   );

   always #5 clk = ~clk;

   always @(posedge start) starts++;

   // behavioural model: register file image plus command progress flags
   logic [7:0]  m_reg [0:8];
   logic [31:0] m_res;
   bit          m_run, m_drain, m_done, m_en, m_pend, m_ce;
   logic        m_wr, m_go, m_cap, m_clr;

   assign m_wr  = cs & wr;
   assign m_go  = m_wr && addr == 4'd9 && data_in[0] && !(m_run || m_drain);
   assign m_cap = m_run && cmd_end && !m_ce;
   assign m_clr = (m_wr && addr == 4'd9 && data_in[1])
                || (cs && rd && addr == 4'd13);

   always @(posedge clk or negedge arst) begin
      if (!arst) begin
         for (int i = 0; i < 9; i++) m_reg[i] <= 8'd0;
         m_res   <= 32'd0;
         m_run   <= 1'b0;
         m_drain <= 1'b0;
         m_done  <= 1'b0;
         m_en    <= 1'b0;
         m_pend  <= 1'b0;
         m_ce    <= 1'b0;
      end else begin
         m_ce <= cmd_end;
         if (m_wr && !(m_run || m_drain)) begin
            if (addr < 4'd8) m_reg[addr] <= data_in;
            else if (addr == 4'd8) m_reg[8] <= {6'd0, data_in[1:0]};
         end
         if (m_go) begin
            m_run  <= 1'b1;
            m_done <= 1'b0;
         end
         if (m_cap) begin
            m_res   <= pkt;
            m_done  <= 1'b1;
            m_run   <= 1'b0;
            m_drain <= 1'b1;
         end
         if (m_drain && !cmd_end) m_drain <= 1'b0;
         if (IRQ) begin
            if (m_wr && addr == 4'd9) m_en <= data_in[3];
            if (m_cap && m_en) m_pend <= 1'b1;
            else if (m_clr) m_pend <= 1'b0;
         end
      end
   end

   function automatic logic [7:0] exp_read(input logic [3:0] a);
      if (a <= 4'd8) return m_reg[a];
      if (a == 4'd9)
         return {3'd0, busy, m_en, m_pend, m_done, m_run | m_drain};
      if (a >= 4'd10 && a <= 4'd13) return m_res[8*(a-10) +: 8];
      return 8'h00;
   endfunction

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("start", 32'(start), 32'(m_run));
      chk("irq", 32'(irq), 32'(m_pend));
      chk("a_operand", a_operand, {m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
      chk("b_operand", b_operand, {m_reg[7], m_reg[6], m_reg[5], m_reg[4]});
      chk("operation", 32'(operation), 32'(m_reg[8][1:0]));
      chk("data_out", 32'(data_out), 32'(exp_read(addr)));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input logic [3:0] a, input logic [7:0] d);
      cs = 1'b1; wr = 1'b1; addr = a; data_in = d;
      tick();
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic rd_reg(input logic [3:0] a);
      cs = 1'b1; rd = 1'b1; addr = a;
      tick();
      cs = 1'b0; rd = 1'b0;
   endtask

   task automatic peek(input string n, input logic [3:0] a,
                       input logic [7:0] e);
      addr = a;
      #2;
      chk(n, 32'(data_out), 32'(e));
      tick();
   endtask

   task automatic wr32(input logic [3:0] base, input logic [31:0] v);
      for (int i = 0; i < 4; i++) wr_reg(base + 4'(i), v[8*i +: 8]);
   endtask

   task automatic chk_res(input logic [31:0] e);
      for (int i = 0; i < 4; i++) peek("result", 4'(10 + i), e[8*i +: 8]);
   endtask

   task automatic wait_start();
      int n = 0;
      while (start !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      chk("start_wait", 32'(start), 32'd1);
   endtask

   task automatic fpu_run(input logic [31:0] res, input int hold);
      wait_start();
      busy = 1'b1;
      tick();
      tick();
      pkt = res;
      cmd_end = 1'b1;
      tick();
      chk("start_drop", 32'(start), 32'd0);
      repeat (hold) tick();
      cmd_end = 1'b0;
      busy = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) tick();
      arst = 1'b1;
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      for (int a = 0; a < 16; a++) peek("rst_reg", 4'(a), 8'h00);

      // 1.0 + 1.1
      wr32(4'd0, 32'h3F800000);
      wr32(4'd4, 32'h3F8CCCCD);
      wr_reg(4'd8, 8'h00);
      wr_reg(4'd9, 8'h01);
      chk("go_start", 32'(start), 32'd1);
      fpu_run(32'h40066666, 1);
      chk_res(32'h40066666);
      peek("status_add", 4'd9, 8'h02);
      chk("model_add", m_res, 32'h40066666);

      // 16 * 32 with interrupt enabled
      wr32(4'd0, 32'h41800000);
      wr32(4'd4, 32'h42000000);
      wr_reg(4'd8, 8'h02);
      chk("op_mul", 32'(operation), 32'(op_mul));
      wr_reg(4'd9, 8'h08);
      wr_reg(4'd9, 8'h09);
      fpu_run(32'h44000000, 1);
      chk("irq_mul", 32'(irq), 32'(IRQ));
      peek("status_mul", 4'd9, IRQ ? 8'h0E : 8'h02);
      chk_res(32'h44000000);
      rd_reg(4'd13);
      chk("irq_rd13", 32'(irq), 32'd0);
      peek("status_rd13", 4'd9, IRQ ? 8'h0A : 8'h02);

      // writes and GO during RUN are ignored
      wr_reg(4'd9, 8'h01);
      wr_reg(4'd0, 8'hFF);
      wr_reg(4'd9, 8'h01);
      chk("a_hold", a_operand, 32'h41800000);
      peek("a0_hold", 4'd0, 8'h00);
      chk("run_start", 32'(start), 32'd1);
      fpu_run(32'h12345678, 1);
      pkt = 32'hDEADBEEF;
      cmd_end = 1'b1;
      tick();
      cmd_end = 1'b0;
      tick();
      chk_res(32'h12345678);
      peek("status_idle", 4'd9, 8'h02);

      // long cmd_end: GO in DRAIN is dropped
      wr_reg(4'd9, 8'h01);
      wait_start();
      busy = 1'b1;
      tick();
      pkt = 32'h11223344;
      cmd_end = 1'b1;
      tick();
      tick();
      wr_reg(4'd9, 8'h01);
      chk("drain_nostart", 32'(start), 32'd0);
      peek("drain_status", 4'd9, 8'h13);
      tick();
      cmd_end = 1'b0;
      busy = 1'b0;
      tick();
      peek("drain_idle", 4'd9, 8'h02);
      chk_res(32'h11223344);
      wr_reg(4'd9, 8'h01);
      chk("rego_start", 32'(start), 32'd1);
      fpu_run(32'h55667788, 1);
      peek("res_msb", 4'd13, 8'h55);

      // reset in the middle of a command
      wr_reg(4'd9, 8'h09);
      fpu_run(32'h40000000, 1);
      wr_reg(4'd9, 8'h09);
      wait_start();
      busy = 1'b1;
      tick();
      #2;
      arst = 1'b0;
      busy = 1'b0;
      #1;
      chk("arst_start", 32'(start), 32'd0);
      chk("arst_irq", 32'(irq), 32'd0);
      for (int a = 0; a < 14; a++) peek("arst_reg", 4'(a), 8'h00);
      arst = 1'b1;
      tick();

      // fresh add after reset
      wr32(4'd0, 32'h3F800000);
      wr32(4'd4, 32'h3F8CCCCD);
      wr_reg(4'd8, 8'h00);
      wr_reg(4'd9, 8'h01);
      fpu_run(32'h40066666, 1);
      chk_res(32'h40066666);
      peek("status_fresh", 4'd9, 8'h02);
      chk("start_count", 32'(starts), 32'd8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
